// File: rtl/my_mem_pkg.sv
// Shared types and helpers for the parity-protected memory (my_mem_par).
package my_mem_pkg;

   localparam int MAX_DATA_W = 64;

   typedef enum logic {
      INIT,
      IDLE
   } state_t;

   // Data is zero-extended by callers; extra zeros do not change the XOR.
   function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/my_mem_array.sv
// Plain single-port storage with registered read; a same-address write returns the old word.
module my_mem_array #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W:0]   wdata,
   output logic [DATA_W:0]   rdata
);

   logic [DATA_W:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (re) begin
         rdata <= mem[addr];
      end
      if (we) begin
         mem[addr] <= wdata;
      end
   end

endmodule

// File: rtl/my_mem_par.sv
// Parity-protected memory: init sweep, parity on write/read, saturating error count.
// Optional MY_MEM_ERR_INJECT_EN adds err_inject to corrupt the stored parity of a write.
module my_mem_par
   import my_mem_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 16,
   parameter int DEPTH      = 2**ADDR_W,
   parameter int PARITY_ODD = 0,
   parameter int CNT_W      = 16
) (
`ifdef MY_MEM_ERR_INJECT_EN
   input  logic              err_inject,
`endif
   input  logic              clk,
   input  logic              reset,
   input  logic              write,
   input  logic              read,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W:0]   data_out,
   output logic              rd_valid,
   output logic              parity_err,
   output logic              oob_err,
   output logic [CNT_W-1:0]  err_count,
   output logic              busy
);

   localparam logic              ODD      = (PARITY_ODD != 0);
   localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

   state_t            state;
   logic [ADDR_W-1:0] init_ptr;
   logic              rd_pend;
   logic              rd_oob;

   logic              in_range;
   logic              accept_rd;
   logic              accept_wr;
   logic              inject;
   logic              arr_we;
   logic              arr_re;
   logic [ADDR_W-1:0] arr_addr;
   logic [DATA_W:0]   arr_wdata;
   logic [DATA_W:0]   arr_rdata;
   logic              rd_mismatch;

`ifdef MY_MEM_ERR_INJECT_EN
   assign inject = err_inject;
`else
   assign inject = 1'b0;
`endif

   // During INIT the sweep owns the array port; afterwards in-range bus requests do.
   always_comb begin
      in_range  = ({1'b0, address} < DEPTH_V);
      accept_rd = (state == IDLE) && read;
      accept_wr = (state == IDLE) && write;
      arr_we    = 1'b0;
      arr_re    = 1'b0;
      arr_addr  = address;
      arr_wdata = {calc_parity(MAX_DATA_W'(data_in), ODD) ^ inject, data_in};
      if (!reset) begin
         if (state == INIT) begin
            arr_we    = 1'b1;
            arr_addr  = init_ptr;
            arr_wdata = {calc_parity('0, ODD), {DATA_W{1'b0}}};
         end else begin
            arr_we = accept_wr && in_range;
            arr_re = accept_rd && in_range;
         end
      end
   end

   assign rd_mismatch = calc_parity(MAX_DATA_W'(arr_rdata[DATA_W-1:0]), ODD) != arr_rdata[DATA_W];

   my_mem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk   (clk),
      .we    (arr_we),
      .re    (arr_re),
      .addr  (arr_addr),
      .wdata (arr_wdata),
      .rdata (arr_rdata)
   );

   // Reads are two-stage: the array captures the word, then this stage checks and presents it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= INIT;
         init_ptr   <= '0;
         busy       <= 1'b1;
         rd_pend    <= 1'b0;
         rd_oob     <= 1'b0;
         data_out   <= '0;
         rd_valid   <= 1'b0;
         parity_err <= 1'b0;
         oob_err    <= 1'b0;
         err_count  <= '0;
      end else begin
         rd_valid   <= rd_pend;
         parity_err <= rd_pend && !rd_oob && rd_mismatch;
         if (rd_pend) begin
            data_out <= rd_oob ? '0 : arr_rdata;
            if (!rd_oob && rd_mismatch && (err_count != CNT_MAX)) begin
               err_count <= err_count + 1'b1;
            end
         end
         rd_pend <= accept_rd;
         rd_oob  <= accept_rd && !in_range;
         oob_err <= (accept_rd || accept_wr) && !in_range;
         case (state)
            INIT: begin
               init_ptr <= init_ptr + 1'b1;
               if (init_ptr == LAST_PTR) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            IDLE: begin
               busy <= 1'b0;
            end
            default: begin
               state <= INIT;
               busy  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_my_mem_par.sv
// Directed and randomized checks of my_mem_par against a transaction-level memory model.
module tb_my_mem_par;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 12;
   localparam int CNT_W  = 2;
   localparam int CNT_SAT = 3;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              write = 1'b0;
   logic              read = 1'b0;
   logic [ADDR_W-1:0] address = '0;
   logic [DATA_W-1:0] data_in = '0;
   logic              err_inject = 1'b0;
   logic [DATA_W:0]   data_out;
   logic              rd_valid;
   logic              parity_err;
   logic              oob_err;
   logic [CNT_W-1:0]  err_count;
   logic              busy;

   int tests = 0;
   int fails = 0;

   logic [DATA_W:0] m_mem [DEPTH];
   logic            m_pend;
   logic [DATA_W:0] m_pend_val;
   logic            m_pend_perr;
   logic [DATA_W:0] e_data_out;
   logic            e_rd_valid;
   logic            e_parity_err;
   logic            e_oob_err;
   int              e_cnt;

   my_mem_par #(
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .DEPTH      (DEPTH),
      .PARITY_ODD (0),
      .CNT_W      (CNT_W)
   ) dut (
`ifdef MY_MEM_ERR_INJECT_EN
      .err_inject (err_inject),
`endif
      .clk        (clk),
      .reset      (reset),
      .write      (write),
      .read       (read),
      .address    (address),
      .data_in    (data_in),
      .data_out   (data_out),
      .rd_valid   (rd_valid),
      .parity_err (parity_err),
      .oob_err    (oob_err),
      .err_count  (err_count),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Even parity: a stored word is good when the XOR over all nine bits is zero.
   task automatic modelReset();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_pend       = 1'b0;
      m_pend_val   = '0;
      m_pend_perr  = 1'b0;
      e_data_out   = '0;
      e_rd_valid   = 1'b0;
      e_parity_err = 1'b0;
      e_oob_err    = 1'b0;
      e_cnt        = 0;
   endtask

   task automatic modelStep(input logic wr, input logic rd, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d, input logic inj);
      e_rd_valid   = m_pend;
      e_parity_err = m_pend && m_pend_perr;
      if (m_pend) e_data_out = m_pend_val;
      if (m_pend && m_pend_perr && e_cnt < CNT_SAT) e_cnt++;
      e_oob_err = (wr || rd) && (int'(a) >= DEPTH);
      m_pend = rd;
      if (rd) begin
         if (int'(a) < DEPTH) begin
            m_pend_val  = m_mem[a];
            m_pend_perr = ^m_pend_val;
         end else begin
            m_pend_val  = '0;
            m_pend_perr = 1'b0;
         end
      end
      if (wr && int'(a) < DEPTH) m_mem[a] = {(^d) ^ inj, d};
   endtask

   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      checkValue({tag, ".data_out"}, 32'(data_out), 32'(e_data_out));
      checkValue({tag, ".rd_valid"}, 32'(rd_valid), 32'(e_rd_valid));
      checkValue({tag, ".parity_err"}, 32'(parity_err), 32'(e_parity_err));
      checkValue({tag, ".oob_err"}, 32'(oob_err), 32'(e_oob_err));
      checkValue({tag, ".err_count"}, 32'(err_count), 32'(e_cnt));
      checkValue({tag, ".busy"}, 32'(busy), 32'd0);
   endtask

   // Called at a negedge; drives one cycle of requests and returns at the next negedge.
   task automatic applyStimulus(input logic wr, input logic rd, input logic [ADDR_W-1:0] a,
                                input logic [DATA_W-1:0] d, input logic inj);
      write      = wr;
      read       = rd;
      address    = a;
      data_in    = d;
      err_inject = inj;
      @(posedge clk);
      modelStep(wr, rd, a, d, inj);
      @(negedge clk);
      write      = 1'b0;
      read       = 1'b0;
      err_inject = 1'b0;
   endtask

   // Releases reset with an out-of-range write held to prove busy requests are ignored.
   task automatic releaseAndInit(input string tag);
      int n;
      n       = 0;
      write   = 1'b1;
      address = 4'hE;
      reset   = 1'b0;
      do begin
         @(posedge clk);
         #1;
         n++;
         checkValue({tag, ".busy_oob"}, 32'(oob_err), 32'd0);
      end while (busy && n < 100);
      write = 1'b0;
      checkValue({tag, ".busy_len"}, 32'(n), 32'(DEPTH));
      @(negedge clk);
   endtask

   initial begin
      logic inj_en;
`ifdef MY_MEM_ERR_INJECT_EN
      inj_en = 1'b1;
`else
      inj_en = 1'b0;
`endif
      modelReset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      checkValue("rst.data_out", 32'(data_out), 32'd0);
      checkValue("rst.rd_valid", 32'(rd_valid), 32'd0);
      checkValue("rst.parity_err", 32'(parity_err), 32'd0);
      checkValue("rst.oob_err", 32'(oob_err), 32'd0);
      checkValue("rst.err_count", 32'(err_count), 32'd0);
      checkValue("rst.busy", 32'(busy), 32'd1);
      @(negedge clk);
      releaseAndInit("init1");

      applyStimulus(1'b0, 1'b1, 4'h5, 8'h00, 1'b0);
      checkOutput("rd5_req");
      applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
      checkOutput("rd5_data");
      checkValue("rd5.valid", 32'(rd_valid), 32'd1);
      checkValue("rd5.data", 32'(data_out), 32'h000);

      applyStimulus(1'b1, 1'b0, 4'h3, 8'hA5, 1'b0);
      applyStimulus(1'b0, 1'b1, 4'h3, 8'h00, 1'b0);
      applyStimulus(1'b1, 1'b1, 4'h4, 8'h01, 1'b0);
      checkValue("rd3.data", 32'(data_out), 32'h0A5);
      checkValue("rd3.perr", 32'(parity_err), 32'd0);
      applyStimulus(1'b0, 1'b1, 4'h4, 8'h00, 1'b0);
      applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
      checkOutput("rd4");
      checkValue("rd4.data", 32'(data_out), 32'h101);

      applyStimulus(1'b1, 1'b1, 4'h3, 8'h3C, 1'b0);
      applyStimulus(1'b0, 1'b1, 4'h3, 8'h00, 1'b0);
      checkValue("rbw.old", 32'(data_out), 32'h0A5);
      applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
      checkValue("rbw.new", 32'(data_out), 32'h03C);
      checkOutput("rbw");

      applyStimulus(1'b1, 1'b0, 4'hE, 8'h77, 1'b0);
      checkValue("oobw.oob", 32'(oob_err), 32'd1);
      applyStimulus(1'b0, 1'b1, 4'hE, 8'h00, 1'b0);
      checkValue("oobr.oob", 32'(oob_err), 32'd1);
      applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
      checkValue("oobr.valid", 32'(rd_valid), 32'd1);
      checkValue("oobr.data", 32'(data_out), 32'h000);
      checkOutput("oobr");

      if (inj_en) begin
         applyStimulus(1'b1, 1'b0, 4'h2, 8'h0F, 1'b1);
         for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 4'h2, 8'h00, 1'b0);
            checkOutput("inj_rd");
         end
         checkValue("inj.count3", 32'(err_count), 32'd3);
         applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
         checkValue("inj.data", 32'(data_out), 32'h10F);
         checkValue("inj.perr", 32'(parity_err), 32'd1);
         checkValue("inj.sat", 32'(err_count), 32'd3);
      end

      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       4'($urandom_range(0, 15)), 8'($urandom),
                       inj_en && ($urandom_range(0, 7) == 0));
         checkOutput("rand");
      end

      applyStimulus(1'b1, 1'b0, 4'h3, 8'h99, 1'b0);
      read    = 1'b1;
      address = 4'h3;
      @(posedge clk);
      @(negedge clk);
      read  = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      checkValue("midrst.rd_valid", 32'(rd_valid), 32'd0);
      checkValue("midrst.err_count", 32'(err_count), 32'd0);
      checkValue("midrst.busy", 32'(busy), 32'd1);
      modelReset();
      @(negedge clk);
      releaseAndInit("init2");
      applyStimulus(1'b0, 1'b1, 4'h3, 8'h00, 1'b0);
      applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
      checkOutput("postrst");
      checkValue("postrst.data", 32'(data_out), 32'h000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
